// File: rtl/run_counter_pkg.sv
// Shared encodings for the run-length counter: FSM states and detection modes.
package run_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_MATCH = 2'd2
   } state_e;

   localparam logic [1:0] MODE_LEVEL    = 2'b00;
   localparam logic [1:0] MODE_PULSE    = 2'b01;
   localparam logic [1:0] MODE_PERIODIC = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (inc && (q_q != '1)) q_d = q_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || clr) q_q <= '0;
      else              q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/run_length_counter.sv
// Consecutive-ones detector: tracks run length, flags threshold hits in
// LEVEL/PULSE/PERIODIC modes and keeps a saturating hit total.
module run_length_counter
   import run_counter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int EVT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clear,
   input  logic                 input1,
   input  logic [WIDTH-1:0]     threshold,
   input  logic [1:0]           mode,
   output logic                 count,
   output logic [WIDTH-1:0]     run_len,
   output logic [EVT_WIDTH-1:0] event_count,
   output logic [1:0]           state
);

   state_e           state_q;
   logic             count_q;
   logic [WIDTH-1:0] phase_q, phase_d;
   logic [WIDTH-1:0] nrl, nph;
   logic             thr_nz, rl_sat, at_thr, lp_hit, ph_hit, hit;

   assign thr_nz = (threshold != '0);
   assign rl_sat = (run_len == '1);
   assign nrl    = rl_sat ? run_len : run_len + WIDTH'(1);
   assign nph    = phase_q + WIDTH'(1);
   assign at_thr = thr_nz && (nrl >= threshold);
   // A saturated run no longer advances, so it must not re-trigger equality.
   assign lp_hit = thr_nz && !rl_sat && (nrl == threshold);
   assign ph_hit = thr_nz && (nph == threshold);
   assign hit    = (mode == MODE_PERIODIC) ? ph_hit : lp_hit;
   assign phase_d = ph_hit ? '0 : nph;

   sat_counter #(.W(WIDTH)) u_run (
      .clk   (clk),
      .reset (reset),
      .clr   (clear | (en & ~input1)),
      .inc   (en & input1),
      .q     (run_len)
   );

   sat_counter #(.W(EVT_WIDTH)) u_evt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (en & input1 & hit),
      .q     (event_count)
   );

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q <= ST_IDLE;
         count_q <= 1'b0;
         phase_q <= '0;
      end else if (en) begin
         if (!input1) begin
            state_q <= ST_IDLE;
            count_q <= 1'b0;
            phase_q <= '0;
         end else begin
            phase_q <= phase_d;
            state_q <= at_thr ? ST_MATCH : ST_RUN;
            case (mode)
               MODE_PULSE:    count_q <= lp_hit;
               MODE_PERIODIC: count_q <= ph_hit;
               default:       count_q <= at_thr;
            endcase
         end
      end else if (mode == MODE_PULSE || mode == MODE_PERIODIC) begin
         // Never stretch a pulse across a stalled sample.
         count_q <= 1'b0;
      end
   end

   assign count = count_q;
   assign state = state_q;

endmodule

// File: tb/tb_run_length_counter.sv
// Bench for run_length_counter: two instances (8/16 and 3/2 widths) checked
// against a behavioural model plus directed expectations.
module tb_run_length_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1, en = 1'b0, clear = 1'b0, input1 = 1'b0;
   logic [7:0] threshold = 8'd0;
   logic [1:0] mode = 2'b00;

   logic       c8, c3;
   logic [7:0] rl8;
   logic [15:0] ev8;
   logic [1:0] st8, st3;
   logic [2:0] rl3;
   logic [1:0] ev3;

   int total = 0, bad = 0;

   // model state, index 0 = WIDTH 8 / EVT 16, index 1 = WIDTH 3 / EVT 2
   int m_rl[2], m_ph[2], m_cnt[2], m_ev[2], m_st[2];
   int maxr[2] = '{255, 7};
   int maxe[2] = '{65535, 3};

   always #5 clk = ~clk;

   run_length_counter #(.WIDTH(8), .EVT_WIDTH(16)) dut8 (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .input1(input1),
      .threshold(threshold), .mode(mode),
      .count(c8), .run_len(rl8), .event_count(ev8), .state(st8)
   );

   run_length_counter #(.WIDTH(3), .EVT_WIDTH(2)) dut3 (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .input1(input1),
      .threshold(threshold[2:0]), .mode(mode),
      .count(c3), .run_len(rl3), .event_count(ev3), .state(st3)
   );

   task automatic model_step(input int k);
      int t, nrl, nph;
      bit phit, lhit, hit;
      t = threshold & maxr[k];
      if (reset || clear) begin
         m_rl[k] = 0; m_ph[k] = 0; m_cnt[k] = 0; m_ev[k] = 0; m_st[k] = 0;
      end else if (en) begin
         if (!input1) begin
            m_rl[k] = 0; m_ph[k] = 0; m_cnt[k] = 0; m_st[k] = 0;
         end else begin
            nrl  = (m_rl[k] < maxr[k]) ? m_rl[k] + 1 : m_rl[k];
            nph  = (m_ph[k] + 1) & maxr[k];
            phit = (t != 0) && (nph == t);
            lhit = (t != 0) && (nrl == t) && (nrl != m_rl[k]);
            hit  = (mode == 2) ? phit : lhit;
            m_ph[k]  = phit ? 0 : nph;
            m_cnt[k] = (mode == 2) ? phit : (mode == 1) ? lhit : ((t != 0) && (nrl >= t));
            m_st[k]  = ((t != 0) && (nrl >= t)) ? 2 : 1;
            m_rl[k]  = nrl;
            if (hit && m_ev[k] < maxe[k]) m_ev[k]++;
         end
      end else if (mode == 1 || mode == 2) begin
         m_cnt[k] = 0;
      end
   endtask

   function automatic logic [26:0] exp8();
      logic [7:0] r; logic [15:0] e; logic [1:0] s;
      r = m_rl[0][7:0]; e = m_ev[0][15:0]; s = m_st[0][1:0];
      return {m_cnt[0][0], r, e, s};
   endfunction

   function automatic logic [7:0] exp3();
      logic [2:0] r; logic [1:0] e; logic [1:0] s;
      r = m_rl[1][2:0]; e = m_ev[1][1:0]; s = m_st[1][1:0];
      return {m_cnt[1][0], r, e, s};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
   endtask

   task automatic do_clear();
      clear = 1'b1; en = 1'b0; input1 = 1'b0;
      cyc();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(); cyc();
      total++;
      if ({c8, rl8, ev8, st8} !== 27'd0) begin
         bad++; $display("FAIL reset_state got=%h exp=0", {c8, rl8, ev8, st8});
      end
      reset = 1'b0; en = 1'b1; input1 = 1'b0;
      cyc();
      total++;
      if ({c8, rl8, ev8, st8} !== 27'd0) begin
         bad++; $display("FAIL reset_idle got=%h exp=0", {c8, rl8, ev8, st8});
      end
      threshold = 8'd3; input1 = 1'b1;
      repeat (5) cyc();
      total++;
      if (rl8 !== 8'd5) begin
         bad++; $display("FAIL reset_prerun got=%0d exp=5", rl8);
      end
      reset = 1'b1;
      cyc();
      total++;
      if ({c8, rl8, ev8, st8, c3, rl3, ev3, st3} !== 35'd0) begin
         bad++; $display("FAIL reset_midrun got=%h exp=0", {c8, rl8, ev8, st8});
      end
      reset = 1'b0;
   endtask

   task automatic test_level();
      int est[7] = '{1, 1, 2, 2, 2, 2, 2};
      do_clear();
      mode = 2'b00; threshold = 8'd3; en = 1'b1; input1 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc();
         total++;
         if ({c8, rl8, st8} !== {(i >= 2), 8'(i + 1), 2'(est[i])}) begin
            bad++;
            $display("FAIL level s=%0d got c=%0d rl=%0d st=%0d exp c=%0d rl=%0d st=%0d",
                     i + 1, c8, rl8, st8, (i >= 2), i + 1, est[i]);
         end
      end
      total++;
      if (ev8 !== 16'd1) begin bad++; $display("FAIL level_ev got=%0d exp=1", ev8); end
      input1 = 1'b0;
      cyc();
      total++;
      if ({c8, st8} !== 3'd0) begin
         bad++; $display("FAIL level_drop got c=%0d st=%0d exp 0 0", c8, st8);
      end
   endtask

   task automatic test_pulse();
      do_clear();
      mode = 2'b01; threshold = 8'd3; en = 1'b1;
      for (int r = 0; r < 2; r++) begin
         input1 = 1'b1;
         for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if (c8 !== (i == 2)) begin
               bad++; $display("FAIL pulse r=%0d s=%0d got=%0d exp=%0d", r, i + 1, c8, (i == 2));
            end
         end
         input1 = 1'b0;
         cyc();
      end
      total++;
      if (ev8 !== 16'd2) begin bad++; $display("FAIL pulse_ev got=%0d exp=2", ev8); end
   endtask

   task automatic test_periodic();
      do_clear();
      mode = 2'b10; threshold = 8'd2; en = 1'b1; input1 = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         cyc();
         total++;
         if ({c8, st8} !== {(i % 2 == 0), (i >= 2) ? 2'd2 : 2'd1}) begin
            bad++; $display("FAIL periodic s=%0d got c=%0d st=%0d", i, c8, st8);
         end
      end
      total++;
      if (ev8 !== 16'd3) begin bad++; $display("FAIL periodic_ev got=%0d exp=3", ev8); end
      input1 = 1'b0;
      cyc();
   endtask

   task automatic test_saturation();
      do_clear();
      mode = 2'b00; threshold = 8'd7; en = 1'b1; input1 = 1'b1;
      repeat (10) cyc();
      total++;
      if ({rl3, ev3, c3} !== {3'd7, 2'd1, 1'b1}) begin
         bad++; $display("FAIL sat_level got rl=%0d ev=%0d c=%0d exp 7 1 1", rl3, ev3, c3);
      end
      en = 1'b0;
      repeat (3) cyc();
      total++;
      if ({rl3, rl8, c3} !== {3'd7, 8'd10, 1'b1}) begin
         bad++; $display("FAIL sat_hold got rl3=%0d rl8=%0d c=%0d exp 7 10 1", rl3, rl8, c3);
      end
      do_clear();
      mode = 2'b01; en = 1'b1; input1 = 1'b1;
      repeat (7) cyc();
      total++;
      if ({c3, c8} !== 2'b11) begin
         bad++; $display("FAIL sat_pulse got c3=%0d c8=%0d exp 1 1", c3, c8);
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total++;
         if ({c3, c8, rl3} !== {2'b00, 3'd7}) begin
            bad++; $display("FAIL sat_pulse_hold got c3=%0d c8=%0d rl=%0d exp 0 0 7", c3, c8, rl3);
         end
      end
   endtask

   task automatic test_corners();
      do_clear();
      mode = 2'b00; threshold = 8'd0; en = 1'b1; input1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         total++;
         if ({c8, st8} !== {1'b0, 2'd1}) begin
            bad++; $display("FAIL thr0 s=%0d got c=%0d st=%0d exp 0 1", i + 1, c8, st8);
         end
      end
      threshold = 8'd2;
      cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      total++;
      if ({c8, rl8, ev8, st8} !== 27'd0) begin
         bad++; $display("FAIL clear_en got=%h exp=0", {c8, rl8, ev8, st8});
      end
      mode = 2'b01; threshold = 8'd1;
      repeat (5) begin
         input1 = 1'b1; cyc();
         input1 = 1'b0; cyc();
      end
      total++;
      if ({ev3, ev8} !== {2'd3, 16'd5}) begin
         bad++; $display("FAIL ev_sat got ev3=%0d ev8=%0d exp 3 5", ev3, ev8);
      end
   endtask

   task automatic test_random();
      do_clear();
      for (int i = 0; i < 500; i++) begin
         en     = ($urandom_range(0, 9) != 0);
         input1 = ($urandom_range(0, 9) < 7);
         clear  = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 14) == 0) threshold = 8'($urandom_range(0, 9));
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
         cyc();
         total++;
         if ({c8, rl8, ev8, st8} !== exp8()) begin
            bad++; $display("FAIL rand_w8 i=%0d got=%h exp=%h", i, {c8, rl8, ev8, st8}, exp8());
         end
         total++;
         if ({c3, rl3, ev3, st3} !== exp3()) begin
            bad++; $display("FAIL rand_w3 i=%0d got=%h exp=%h", i, {c3, rl3, ev3, st3}, exp3());
         end
      end
      clear = 1'b0;
   endtask

   initial begin
      test_reset();
      test_level();
      test_pulse();
      test_periodic();
      test_saturation();
      test_corners();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
